// File: rtl/conv_pixel_feeder.sv
// Raster-order frame reader feeding the 3x3 convolution line buffer through a 2-entry skid FIFO.
// Define FEED_ZERO_PAD_EN to emit a zero-bordered (IMG_W+2) x (IMG_H+2) frame.
module conv_pixel_feeder #(
  parameter int WIDTH  = 9,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [WIDTH-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              win_valid,
  output logic              frame_last
);

`ifdef FEED_ZERO_PAD_EN
  localparam int PW = IMG_W + 2;
  localparam int PH = IMG_H + 2;
`else
  localparam int PW = IMG_W;
  localparam int PH = IMG_H;
`endif
  localparam int TOTAL = PW * PH;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int CW    = $clog2(PW + 1);
  localparam int RW    = $clog2(PH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);
  localparam logic [CW-1:0]    COL_LAST = CW'(PW - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(PH - 1);
  localparam logic [CW-1:0]    COL_TWO  = CW'(2);
  localparam logic [RW-1:0]    ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              infl_q, infl_d;
  logic [CW-1:0]     oc_q, oc_d;
  logic [RW-1:0]     orow_q, orow_d;
  logic [WIDTH-1:0]  data0_q, data0_d, data1_q, data1_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              xfer, can_issue, border_rd;
  logic [1:0]        occ;
  logic [WIDTH-1:0]  push_data;

`ifdef FEED_ZERO_PAD_EN
  logic [CW-1:0]     rcol_q, rcol_d;
  logic [RW-1:0]     rrow_q, rrow_d;
  logic              infl_zero_q, infl_zero_d;

  assign border_rd = (rrow_q == '0) || (rrow_q == ROW_LAST) ||
                     (rcol_q == '0) || (rcol_q == COL_LAST);
  assign push_data = infl_zero_q ? '0 : mem_rdata;
`else
  assign border_rd = 1'b0;
  assign push_data = mem_rdata;
`endif

  assign pix_valid  = (cnt_q != 2'd0);
  assign xfer       = pix_valid && pix_ready;
  // In-flight plus buffered after this cycle's pop; issuing keeps it at most 2.
  assign occ        = 2'(infl_q) + cnt_q - 2'(xfer);
  assign can_issue  = (state_q == RUN) && (occ < 2'd2);
  assign mem_rd_en  = can_issue && !border_rd;
  assign mem_addr   = mem_rd_en ? addr_q : '0;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign pix_data   = pix_valid ? data0_q : '0;
  assign win_valid  = pix_valid && (orow_q >= ROW_TWO) && (oc_q >= COL_TWO);
  assign frame_last = pix_valid && (orow_q == ROW_LAST) && (oc_q == COL_LAST);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rd_cnt_d = rd_cnt_q;
    infl_d   = can_issue;
    oc_d     = oc_q;
    orow_d   = orow_q;
`ifdef FEED_ZERO_PAD_EN
    rcol_d      = rcol_q;
    rrow_d      = rrow_q;
    infl_zero_d = can_issue && border_rd;
`endif

    if (mem_rd_en) addr_d = addr_q + 1'b1;

    if (can_issue) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
`ifdef FEED_ZERO_PAD_EN
      if (rcol_q == COL_LAST) begin
        rcol_d = '0;
        rrow_d = rrow_q + 1'b1;
      end else begin
        rcol_d = rcol_q + 1'b1;
      end
`endif
    end

    if (xfer) begin
      if (oc_q == COL_LAST) begin
        oc_d   = '0;
        orow_d = (orow_q == ROW_LAST) ? '0 : orow_q + 1'b1;
      end else begin
        oc_d = oc_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          addr_d   = base_addr;
          rd_cnt_d = '0;
          oc_d     = '0;
          orow_d   = '0;
`ifdef FEED_ZERO_PAD_EN
          rcol_d   = '0;
          rrow_d   = '0;
`endif
        end
      end
      RUN:     if (can_issue && (rd_cnt_q == CNT_LAST)) state_d = DRAIN;
      DRAIN:   if (xfer && frame_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift-style FIFO: data0 is always the head, so pix_data needs no read pointer.
  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    cnt_d   = cnt_q;
    case ({infl_q, xfer})
      2'b10: begin
        if (cnt_q == 2'd0) data0_d = push_data;
        else               data1_d = push_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        data0_d = data1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          data0_d = push_data;
        end else begin
          data0_d = data1_q;
          data1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rd_cnt_q <= '0;
      infl_q   <= 1'b0;
      oc_q     <= '0;
      orow_q   <= '0;
      data0_q  <= '0;
      data1_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_cnt_q <= rd_cnt_d;
      infl_q   <= infl_d;
      oc_q     <= oc_d;
      orow_q   <= orow_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef FEED_ZERO_PAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcol_q      <= '0;
      rrow_q      <= '0;
      infl_zero_q <= 1'b0;
    end else begin
      rcol_q      <= rcol_d;
      rrow_q      <= rrow_d;
      infl_zero_q <= infl_zero_d;
    end
  end
`endif

endmodule
